// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - LOOK-algorithm car scheduler: call latching, floor counter, direction and door dwell
module elevator_call_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 100
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [NUM_FLOORS-1:0] hall_req,
  input  logic [NUM_FLOORS-1:0] cab_req,
  input  logic                  arrive,
  input  logic                  door_hold,
  output logic                  move_en,
  output logic                  move_dir,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [1:0]            state_dbg,
  output logic                  arrive_err
);

  localparam int FW1     = FLOOR_W + 1;
  localparam int TIMER_W = $clog2(DOOR_CYCLES) + 1;
  localparam logic [FW1-1:0]        TOP    = FW1'(NUM_FLOORS - 1);
  localparam logic [TIMER_W-1:0]    T_LAST = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE    = NUM_FLOORS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_DOOR = 2'b11
  } state_t;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [FW1-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (p[i] && (FW1'(i) > f)) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [FW1-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) if (p[i] && (FW1'(i) < f)) r = 1'b1;
    return r;
  endfunction

  function automatic logic [FW1-1:0] nearest_above(input logic [NUM_FLOORS-1:0] p, input logic [FW1-1:0] f);
    logic [FW1-1:0] r;
    r = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) if (p[i] && (FW1'(i) > f)) r = FW1'(i);
    return r;
  endfunction

  function automatic logic [FW1-1:0] nearest_below(input logic [NUM_FLOORS-1:0] p, input logic [FW1-1:0] f);
    logic [FW1-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_FLOORS; i++) if (p[i] && (FW1'(i) < f)) r = FW1'(i);
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic                    last_up_q, last_up_d;
  logic                    err_q, err_d;

  logic [FW1-1:0]          floor_w, nxt_up, nxt_dn, dist_up, dist_dn;
  logic                    above, below, above_nu, below_nu, above_nd, below_nd;
  logic                    restart;
  logic [NUM_FLOORS-1:0]   clr;

  assign floor_w  = {1'b0, floor_q};
  assign nxt_up   = floor_w + 1'b1;
  assign nxt_dn   = floor_w - 1'b1;
  assign above    = any_above(pending_q, floor_w);
  assign below    = any_below(pending_q, floor_w);
  assign above_nu = any_above(pending_q, nxt_up);
  assign below_nu = any_below(pending_q, nxt_up);
  assign above_nd = any_above(pending_q, nxt_dn);
  assign below_nd = any_below(pending_q, nxt_dn);
  assign dist_up  = nearest_above(pending_q, floor_w) - floor_w;
  assign dist_dn  = floor_w - nearest_below(pending_q, floor_w);
  assign restart  = hall_req[floor_q] | cab_req[floor_q] | door_hold;

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    timer_d   = timer_q;
    last_up_d = last_up_q;
    err_d     = err_q;
    clr       = '0;
    case (state_q)
      S_IDLE: begin
        if (arrive) err_d = 1'b1;
        if (pending_q[floor_q])   state_d = S_DOOR;
        else if (above && below)  state_d = (dist_up < dist_dn) ? S_UP : S_DOWN;
        else if (above)           state_d = S_UP;
        else if (below)           state_d = S_DOWN;
      end
      S_UP: begin
        last_up_d = 1'b1;
        if (arrive) begin
          if (floor_w == TOP) begin
            err_d   = 1'b1;
            state_d = S_DOOR;
          end else begin
            floor_d = nxt_up[FLOOR_W-1:0];
            if (pending_q[nxt_up[FLOOR_W-1:0]]) state_d = S_DOOR;
            else if (above_nu)                  state_d = S_UP;
            else if (below_nu)                  state_d = S_DOWN;
            else                                state_d = S_IDLE;
          end
        end
      end
      S_DOWN: begin
        last_up_d = 1'b0;
        if (arrive) begin
          if (floor_q == '0) begin
            err_d   = 1'b1;
            state_d = S_DOOR;
          end else begin
            floor_d = nxt_dn[FLOOR_W-1:0];
            if (pending_q[nxt_dn[FLOOR_W-1:0]]) state_d = S_DOOR;
            else if (below_nd)                  state_d = S_DOWN;
            else if (above_nd)                  state_d = S_UP;
            else                                state_d = S_IDLE;
          end
        end
      end
      default: begin
        if (arrive) err_d = 1'b1;
        // timer is zero outside DOOR because expiry always rewinds it
        if (restart) begin
          timer_d = '0;
        end else if (timer_q == T_LAST) begin
          timer_d = '0;
          if (last_up_q) state_d = above ? S_UP : (below ? S_DOWN : S_IDLE);
          else           state_d = below ? S_DOWN : (above ? S_UP : S_IDLE);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    endcase
    if ((state_q == S_DOOR) || (state_d == S_DOOR)) clr = ONE << floor_d;
    pending_d = (pending_q | hall_req | cab_req) & ~clr;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      pending_q <= '0;
      timer_q   <= '0;
      last_up_q <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      last_up_q <= last_up_d;
      err_q     <= err_d;
    end
  end

  assign move_en    = (state_q == S_UP) || (state_q == S_DOWN);
  assign move_dir   = (state_q == S_UP);
  assign door_open  = (state_q == S_DOOR);
  assign floor      = floor_q;
  assign pending    = pending_q;
  assign state_dbg  = state_q;
  assign arrive_err = err_q;

endmodule
